// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - segment encodings, digit field indices and blank levels for the scan display
package disp_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  localparam logic [2:0] DIG_CNT_LO = 3'd0;
  localparam logic [2:0] DIG_CNT_HI = 3'd1;
  localparam logic [2:0] DIG_VAL_LO = 3'd2;
  localparam logic [2:0] DIG_VAL_HI = 3'd3;
  localparam logic [2:0] DIG_COL_LO = 3'd4;
  localparam logic [2:0] DIG_COL_HI = 3'd5;
  localparam logic [2:0] DIG_ROW_LO = 3'd6;
  localparam logic [2:0] DIG_ROW_HI = 3'd7;

  // Active-low {g,f,e,d,c,b,a}, indexed by nibble value
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_HEX[nib];
  endfunction

endpackage

// File: rtl/disp_refresh_timer.sv
// rtl/disp_refresh_timer.sv - per-digit prescaler, digit index and frame-wrap pulse
module disp_refresh_timer #(
  parameter int TICKS_PER_DIGIT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [2:0] digit_idx,
  output logic       frame_tick
);

  localparam int PW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam logic [PW-1:0] TERM = PW'(TICKS_PER_DIGIT - 1);

  logic [PW-1:0] prescaler;
  logic          term;

  assign term       = (prescaler == TERM);
  assign frame_tick = term && (digit_idx == 3'd7);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      digit_idx <= '0;
    end else if (term) begin
      prescaler <= '0;
      digit_idx <= digit_idx + 3'd1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

endmodule

// File: rtl/disp_scan_scheduler.sv
// rtl/disp_scan_scheduler.sv - tear-free 8-digit hex scan of row/col/pixel and update count; optional DISP_BLINK_EN
module disp_scan_scheduler
  import disp_pkg::*;
#(
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLINK_FRAMES    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] row_index,
  input  logic [7:0] col_index,
  input  logic [7:0] pixel_val,
  input  logic       data_valid,
  input  logic       disp_en,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick,
  output logic [7:0] pkt_cnt
);

  logic [2:0] digit_idx;
  logic [7:0] stg_row, stg_col, stg_val;
  logic [7:0] shd_row, shd_col, shd_val;
  logic       pending;
  logic       commit;
  logic [3:0] nibble;
  logic       blink_blank;

  disp_refresh_timer #(
    .TICKS_PER_DIGIT(TICKS_PER_DIGIT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .digit_idx (digit_idx),
    .frame_tick(frame_tick)
  );

  assign commit = frame_tick && pending;

  // Shadow only moves at the frame wrap; a strobe on that same cycle re-arms pending
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stg_row <= '0;
      stg_col <= '0;
      stg_val <= '0;
      shd_row <= '0;
      shd_col <= '0;
      shd_val <= '0;
      pending <= 1'b0;
      pkt_cnt <= '0;
    end else begin
      if (data_valid) begin
        stg_row <= row_index;
        stg_col <= col_index;
        stg_val <= pixel_val;
      end
      if (commit) begin
        shd_row <= stg_row;
        shd_col <= stg_col;
        shd_val <= stg_val;
        pkt_cnt <= pkt_cnt + 8'd1;
      end
      if (data_valid)
        pending <= 1'b1;
      else if (frame_tick)
        pending <= 1'b0;
    end
  end

`ifdef DISP_BLINK_EN
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [BW-1:0] blink_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      blink_cnt <= '0;
    else if (commit)
      blink_cnt <= BW'(BLINK_FRAMES);
    else if (frame_tick && (blink_cnt != '0))
      blink_cnt <= blink_cnt - 1'b1;
  end

  assign blink_blank = blink_cnt[0] && (digit_idx >= DIG_VAL_LO);
`else
  assign blink_blank = 1'b0 & (BLINK_FRAMES == 0);
`endif

  always_comb begin
    nibble = 4'h0;
    case (digit_idx)
      DIG_ROW_HI: nibble = shd_row[7:4];
      DIG_ROW_LO: nibble = shd_row[3:0];
      DIG_COL_HI: nibble = shd_col[7:4];
      DIG_COL_LO: nibble = shd_col[3:0];
      DIG_VAL_HI: nibble = shd_val[7:4];
      DIG_VAL_LO: nibble = shd_val[3:0];
      DIG_CNT_HI: nibble = pkt_cnt[7:4];
      DIG_CNT_LO: nibble = pkt_cnt[3:0];
      default:    nibble = 4'h0;
    endcase
  end

  // Registered pins: anode, segments and dp switch on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else if (!disp_en || blink_blank) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= ~(8'b1 << digit_idx);
      seg <= hex_to_seg(nibble);
      dp  <= !((digit_idx == DIG_ROW_LO) || (digit_idx == DIG_COL_LO) ||
               (digit_idx == DIG_VAL_LO));
    end
  end

endmodule

// File: tb/tb_disp_scan_scheduler.sv
// tb/tb_disp_scan_scheduler.sv - directed table-driven bench for disp_scan_scheduler
module tb_disp_scan_scheduler;

  localparam int TPD   = 4;
  localparam int FRAME = 8 * TPD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] row_index = '0;
  logic [7:0] col_index = '0;
  logic [7:0] pixel_val = '0;
  logic       data_valid = 1'b0;
  logic       disp_en = 1'b1;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;
  logic [7:0] pkt_cnt;

  disp_scan_scheduler #(
    .TICKS_PER_DIGIT(TPD),
    .BLINK_FRAMES   (64)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .row_index (row_index),
    .col_index (col_index),
    .pixel_val (pixel_val),
    .data_valid(data_valid),
    .disp_en   (disp_en),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick),
    .pkt_cnt   (pkt_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc;
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;
  logic [7:0] cur_r = '0, cur_c = '0, cur_v = '0, cur_cnt = '0;

  typedef struct {
    int              n;
    logic [2:0][7:0] r;
    logic [2:0][7:0] c;
    logic [2:0][7:0] v;
    bit              en;
    logic [7:0]      er, ec, ev, ecnt;
  } vec_t;

  vec_t tbl [5];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [3:0] nib_of(input int d, input logic [7:0] r, c, v, cnt);
    case (d)
      7: return r[7:4];
      6: return r[3:0];
      5: return c[7:4];
      4: return c[3:0];
      3: return v[7:4];
      2: return v[3:0];
      1: return cnt[7:4];
      default: return cnt[3:0];
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_an"}, an, 8'hFF);
    chk({tag, "_seg"}, {1'b0, seg}, 8'h7F);
    chk({tag, "_dp"}, {7'b0, dp}, 8'h01);
    chk({tag, "_frame_tick"}, {7'b0, frame_tick}, 8'h00);
    chk({tag, "_pkt_cnt"}, pkt_cnt, 8'h00);
  endtask

  // Expected pins follow from the bench's own cycle count since reset release
  task automatic check_cycles(input int n, input logic [7:0] r, c, v, cnt, input bit en);
    for (int i = 0; i < n; i++) begin
      int d;
      logic [7:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      step();
      d = int'(((cyc - 1) / TPD) % 8);
      e_an  = en ? ~(8'b1 << d) : 8'hFF;
      e_seg = en ? seg_of(nib_of(d, r, c, v, cnt)) : 7'h7F;
      e_dp  = en ? !(d == 6 || d == 4 || d == 2) : 1'b1;
      chk("an", an, e_an);
      chk("seg", {1'b0, seg}, {1'b0, e_seg});
      chk("dp", {7'b0, dp}, {7'b0, e_dp});
      chk("frame_tick", {7'b0, frame_tick}, {7'b0, (cyc % FRAME) == FRAME - 1});
      if ((cyc % FRAME) != 0)
        chk("pkt_cnt", pkt_cnt, cnt);
    end
  endtask

  task automatic strobe(input logic [7:0] r, c, v);
    row_index  = r;
    col_index  = c;
    pixel_val  = v;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  initial begin
    tbl[0] = '{n: 1, r: {8'h00, 8'h00, 8'h12}, c: {8'h00, 8'h00, 8'hAB}, v: {8'h00, 8'h00, 8'hF0},
               en: 1'b1, er: 8'h12, ec: 8'hAB, ev: 8'hF0, ecnt: 8'd1};
    tbl[1] = '{n: 3, r: {8'h77, 8'h44, 8'h11}, c: {8'h88, 8'h55, 8'h22}, v: {8'h99, 8'h66, 8'h33},
               en: 1'b1, er: 8'h77, ec: 8'h88, ev: 8'h99, ecnt: 8'd2};
    tbl[2] = '{n: 1, r: {8'h00, 8'h00, 8'h5A}, c: {8'h00, 8'h00, 8'hC3}, v: {8'h00, 8'h00, 8'h7E},
               en: 1'b0, er: 8'h5A, ec: 8'hC3, ev: 8'h7E, ecnt: 8'd3};
    tbl[3] = '{n: 0, r: '0, c: '0, v: '0,
               en: 1'b1, er: 8'h5A, ec: 8'hC3, ev: 8'h7E, ecnt: 8'd3};
    tbl[4] = '{n: 1, r: {8'h00, 8'h00, 8'h96}, c: {8'h00, 8'h00, 8'hDE}, v: {8'h00, 8'h00, 8'hC8},
               en: 1'b1, er: 8'h96, ec: 8'hDE, ev: 8'hC8, ecnt: 8'd4};

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;

    // Idle scan: zeros everywhere, frame_tick every 32 cycles, no commits
    check_cycles(2 * FRAME, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

    for (int k = 0; k < 5; k++) begin
      disp_en = tbl[k].en;
      check_cycles(5, cur_r, cur_c, cur_v, cur_cnt, tbl[k].en);
      for (int j = 0; j < tbl[k].n; j++)
        strobe(tbl[k].r[j], tbl[k].c[j], tbl[k].v[j]);
      check_cycles(FRAME - int'(cyc % FRAME), cur_r, cur_c, cur_v, cur_cnt, tbl[k].en);
      check_cycles(FRAME, tbl[k].er, tbl[k].ec, tbl[k].ev, tbl[k].ecnt, tbl[k].en);
      cur_r = tbl[k].er;
      cur_c = tbl[k].ec;
      cur_v = tbl[k].ev;
      cur_cnt = tbl[k].ecnt;
    end

    // Strobe on the frame_tick cycle while pending: old staging commits, new one next frame
    check_cycles(3, cur_r, cur_c, cur_v, cur_cnt, 1'b1);
    strobe(8'hA1, 8'hB2, 8'hC3);
    check_cycles(FRAME - 1 - int'(cyc % FRAME), cur_r, cur_c, cur_v, cur_cnt, 1'b1);
    chk("collide_frame_tick", {7'b0, frame_tick}, 8'h01);
    strobe(8'hD4, 8'hE5, 8'hF6);
    check_cycles(FRAME, 8'hA1, 8'hB2, 8'hC3, cur_cnt + 8'd1, 1'b1);
    check_cycles(FRAME, 8'hD4, 8'hE5, 8'hF6, cur_cnt + 8'd2, 1'b1);
    cur_r = 8'hD4;
    cur_c = 8'hE5;
    cur_v = 8'hF6;
    cur_cnt = cur_cnt + 8'd2;

    // Drive pkt_cnt to 255 then across the wrap
    while (cur_cnt != 8'hFF) begin
      strobe(8'h3C, 8'hE7, 8'h5D);
      repeat (FRAME - int'(cyc % FRAME)) step();
      cur_cnt = cur_cnt + 8'd1;
    end
    cur_r = 8'h3C;
    cur_c = 8'hE7;
    cur_v = 8'h5D;
    check_cycles(FRAME, cur_r, cur_c, cur_v, 8'hFF, 1'b1);
    check_cycles(5, cur_r, cur_c, cur_v, 8'hFF, 1'b1);
    strobe(8'h0F, 8'h1E, 8'h2D);
    check_cycles(FRAME - int'(cyc % FRAME), cur_r, cur_c, cur_v, 8'hFF, 1'b1);
    check_cycles(FRAME, 8'h0F, 8'h1E, 8'h2D, 8'h00, 1'b1);

    // Async reset mid-digit with an update pending: it must never commit
    check_cycles(3, 8'h0F, 8'h1E, 8'h2D, 8'h00, 1'b1);
    strobe(8'h42, 8'h42, 8'h42);
    step();
    step();
    #2 reset = 1'b0;
    #1 check_reset_vals("async_reset");
    @(negedge clk);
    check_reset_vals("reset_held");
    reset = 1'b1;
    check_cycles(2 * FRAME, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_scan_scheduler.md
Name: disp_scan_scheduler

Overview:
Time-multiplexes the 8-digit common-anode 7-segment display. It shows row_index, col_index and pixel_val from the Rx FSM, plus an accepted-update counter, as hex. New values are staged on arrival and committed only at a frame boundary, so the display never tears mid-scan. Sits between the Rx FSM outputs and the board anode/segment pins.

Parameters:
TICKS_PER_DIGIT, 100000, clk cycles each digit is driven (1 ms at 100 MHz); must be >= 2
BLINK_FRAMES, 64, frames of blink after each commit (used only with DISP_BLINK_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
row_index  in  8  row value from Rx FSM
col_index  in  8  column value from Rx FSM
pixel_val  in  8  pixel value from Rx FSM
data_valid  in  1  one-cycle strobe: the three inputs are valid this cycle
disp_en  in  1  1 = drive display; 0 = blank outputs
an  out  8  digit anodes, active-low, one-hot-low when enabled
seg  out  7  segments {g,f,e,d,c,b,a}, active-low
dp  out  1  decimal point, active-low
frame_tick  out  1  one-cycle pulse when the scan wraps from digit 7 to digit 0
pkt_cnt  out  8  number of committed updates, mod 256

Behaviour:
- Reset values (async, on reset low):
  - an=8'hFF, seg=7'h7F, dp=1, frame_tick=0, pkt_cnt=0.
  - Prescaler=0, digit_idx=0, pending=0.
  - Staging and shadow registers = 0.
- Prescaler:
  - Counts 0..TICKS_PER_DIGIT-1, then wraps.
  - At terminal count, digit_idx increments 0..7, wrapping 7->0.
  - frame_tick=1 for exactly the cycle in which digit_idx is 7 and the prescaler is terminal.
- Counters free-run regardless of disp_en.
- Staging:
  - data_valid=1 loads staging {row,col,val} and sets pending=1.
  - Latest write wins; multiple strobes within one frame produce one commit.
- Commit, on a frame_tick cycle with pending=1:
  - shadow <= staging, pkt_cnt <= pkt_cnt+1 (wraps 255->0), pending <= 0.
  - If data_valid is also 1 in that cycle: shadow takes the old staging value, staging takes the new inputs, pending stays 1, and the next frame commits again.
- Digit map (nibble shown on each digit):
  - 7=row[7:4], 6=row[3:0]
  - 5=col[7:4], 4=col[3:0]
  - 3=val[7:4], 2=val[3:0]
  - 1=pkt_cnt[7:4], 0=pkt_cnt[3:0]
- dp=0 on digits 6, 4 and 2 (field separators); dp=1 otherwise.
- Hex encoding (active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Output latency:
  - an, seg and dp are registered and all change together one cycle after digit_idx changes.
  - an[i]=0 only for the registered digit index i.
- disp_en=0: an=FF, seg=7F, dp=1 from the next cycle on. Staging, commit and pkt_cnt continue normally.
- Reset asserted mid-frame: everything returns to reset values immediately. Any pending update is discarded.

Optional Feature:
Macro DISP_BLINK_EN.
- Defined:
  - A commit loads a blink counter with BLINK_FRAMES; it decrements on each frame_tick until 0.
  - While nonzero and its LSB is 1, digits 7..2 are blanked (an high for those digits).
  - Digits 1..0 are unaffected.
  - A new commit reloads the counter.
- Undefined: no blink counter exists; the display is always steady.

Decomposition:
- Package disp_pkg holds:
  - the SEG_HEX[16] constant table,
  - the digit field-index localparams (DIG_ROW_HI..DIG_CNT_LO),
  - the blank constants SEG_OFF=7'h7F and AN_OFF=8'hFF.
- One sub-module, disp_refresh_timer: prescaler, digit_idx and frame_tick; parameterised by TICKS_PER_DIGIT.

Test Plan (TICKS_PER_DIGIT=4, so one frame = 32 cycles):
1. Reset release, disp_en=1 -> an walks FE, FD, FB ... 7F, each held for 4 cycles. All digits show seg=40. frame_tick pulses every 32 cycles. pkt_cnt=0.
2. data_valid with row=12, col=AB, val=F0 mid-frame -> the display is unchanged until the next frame_tick. Then digits 7..2 show 1,2,A,b,F,0 (seg 79, 24, 08, 03, 0E, 40) and pkt_cnt=1.
3. Three data_valid strobes in one frame (11/22/33, 44/55/66, 77/88/99) -> only 77/88/99 is displayed, and pkt_cnt increments by exactly 1.
4. data_valid on the same cycle as frame_tick while pending -> the old staged value commits that frame. The new value commits on the following frame_tick, and pkt_cnt increments twice in total.
5. disp_en=0 while updates arrive -> an=FF, seg=7F, dp=1, while pkt_cnt still increments. Re-enabling shows the latest committed data.
6. reset pulsed low mid-digit with pending=1 -> all outputs are at reset values immediately. After release, the pending update never commits and pkt_cnt stays 0.
